// File: rtl/ascon_share_loader.sv
// Purpose  : serial-to-parallel share loader; assembles key/nonce/AD/PT (SHARES shares each) from W-bit lanes.
// Latency  : data_valid_o rises on the edge after the BEATS-th accepted beat; ack re-opens input next cycle.
// Backpress: in_ready_o low in IDLE and FULL; FULL holds fields until data_ack_i (or clear_i).
//
// Ports:
//   clk, rst                        rising-edge clock, asynchronous active-low reset
//   key_i/nonce_i/ad_i/pt_i         one SHARES*W-bit beat per field, share s at [s*W +: W], MSB-first
//   in_valid_i / in_ready_o         beat handshake
//   clear_i                         synchronous abort back to an empty LOAD
//   key_o/nonce_o/ad_o/pt_o         assembled fields, share s at [s*LEN +: LEN]
//   data_valid_o / data_ack_i       output hand-off to the core
//   beat_o                          beats accepted in the current load
//
// Build option: define ASCON_LOADER_ZEROIZE_EN to wipe all field registers on ack-from-FULL and on clear_i.

// Purpose  : one shared field register; shifts lanes in MSB-first while its beat window is open.
// Latency  : register updates on the accepting edge.
// Backpress: none of its own; follows the shift enable from the loader.
module ascon_share_field #(
    parameter int LEN    = 128,
    parameter int W      = 1,
    parameter int SHARES = 3,
    parameter int NB     = 128,
    parameter int BW     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_shift,
    input  logic                   i_zero,
    input  logic [BW-1:0]          i_beat,
    input  logic [SHARES*W-1:0]    i_lane,
    output logic [SHARES*LEN-1:0]  o_field
);
    // On the last beat of a field whose length is not a multiple of W only the
    // top REM lane bits belong to the field; shifting the concatenation right by
    // W-REM drops the unused low lane bits.
    localparam int REM = LEN % W;
    localparam int SH  = (REM == 0) ? 0 : (W - REM);

    logic                  w_active;
    logic                  w_last;
    logic [SHARES*LEN-1:0] w_next;
    logic [SHARES*LEN-1:0] r_field;

    assign w_active = (i_beat < BW'(NB));
    assign w_last   = (i_beat == BW'(NB - 1));

    always_comb begin
        logic [LEN+W-1:0] w_cat;
        logic [LEN+W-1:0] w_sh;
        w_next = r_field;
        w_cat  = '0;
        w_sh   = '0;
        for (int s = 0; s < SHARES; s++) begin
            w_cat = {r_field[s*LEN +: LEN], i_lane[s*W +: W]};
            w_sh  = w_last ? (w_cat >> SH) : w_cat;
            w_next[s*LEN +: LEN] = w_sh[LEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_field <= '0;
        end else if (i_zero) begin
            r_field <= '0;
        end else if (i_shift && w_active) begin
            r_field <= w_next;
        end
    end

    assign o_field = r_field;
endmodule

module ascon_share_loader #(
    parameter int KLEN   = 128,
    parameter int NLEN   = 128,
    parameter int ALEN   = 40,
    parameter int PLEN   = 40,
    parameter int W      = 1,
    parameter int SHARES = 3,
    localparam int KB    = (KLEN + W - 1) / W,
    localparam int NB    = (NLEN + W - 1) / W,
    localparam int AB    = (ALEN + W - 1) / W,
    localparam int PB    = (PLEN + W - 1) / W,
    localparam int M1    = (KB > NB) ? KB : NB,
    localparam int M2    = (AB > PB) ? AB : PB,
    localparam int BEATS = (M1 > M2) ? M1 : M2,
    localparam int BW    = $clog2(BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SHARES*W-1:0]     key_i,
    input  logic [SHARES*W-1:0]     nonce_i,
    input  logic [SHARES*W-1:0]     ad_i,
    input  logic [SHARES*W-1:0]     pt_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    clear_i,
    output logic [SHARES*KLEN-1:0]  key_o,
    output logic [SHARES*NLEN-1:0]  nonce_o,
    output logic [SHARES*ALEN-1:0]  ad_o,
    output logic [SHARES*PLEN-1:0]  pt_o,
    output logic                    data_valid_o,
    input  logic                    data_ack_i,
    output logic [BW-1:0]           beat_o
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [BW-1:0] r_beat;
    logic [BW-1:0] w_beat_nxt;
    logic          w_accept;
    logic          w_shift;
    logic          w_zero;

    assign w_accept = in_valid_i && (r_state == S_LOAD);
    // An abort on the same edge must not let the beat land in the fields.
    assign w_shift  = w_accept && !clear_i;

`ifdef ASCON_LOADER_ZEROIZE_EN
    assign w_zero = clear_i || ((r_state == S_FULL) && data_ack_i);
`else
    assign w_zero = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        case (r_state)
            S_IDLE: w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_accept) begin
                    w_beat_nxt = r_beat + BW'(1);
                    if (r_beat == BW'(BEATS - 1)) begin
                        w_state_nxt = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (data_ack_i) begin
                    w_state_nxt = S_LOAD;
                    w_beat_nxt  = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (clear_i) begin
            w_state_nxt = S_LOAD;
            w_beat_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    assign in_ready_o   = (r_state == S_LOAD);
    assign data_valid_o = (r_state == S_FULL);
    assign beat_o       = r_beat;

    ascon_share_field #(.LEN(KLEN), .W(W), .SHARES(SHARES), .NB(KB), .BW(BW)) u_key (
        .clk(clk), .rst(rst), .i_shift(w_shift), .i_zero(w_zero),
        .i_beat(r_beat), .i_lane(key_i), .o_field(key_o)
    );
    ascon_share_field #(.LEN(NLEN), .W(W), .SHARES(SHARES), .NB(NB), .BW(BW)) u_nonce (
        .clk(clk), .rst(rst), .i_shift(w_shift), .i_zero(w_zero),
        .i_beat(r_beat), .i_lane(nonce_i), .o_field(nonce_o)
    );
    ascon_share_field #(.LEN(ALEN), .W(W), .SHARES(SHARES), .NB(AB), .BW(BW)) u_ad (
        .clk(clk), .rst(rst), .i_shift(w_shift), .i_zero(w_zero),
        .i_beat(r_beat), .i_lane(ad_i), .o_field(ad_o)
    );
    ascon_share_field #(.LEN(PLEN), .W(W), .SHARES(SHARES), .NB(PB), .BW(BW)) u_pt (
        .clk(clk), .rst(rst), .i_shift(w_shift), .i_zero(w_zero),
        .i_beat(r_beat), .i_lane(pt_i), .o_field(pt_o)
    );
endmodule

// File: tb/tb_ascon_share_loader.sv
// Purpose  : self-checking bench for ascon_share_loader at W=3 (non-divisible lengths, 43 beats).
// Latency  : expects data_valid_o after 43 accepted beats, in_ready_o the cycle after ack.
// Backpress: random in_valid_i gaps, delayed ack with in_valid_i held high in FULL.
module tb_ascon_share_loader;
    localparam int KL = 128;
    localparam int NL = 128;
    localparam int AL = 40;
    localparam int PL = 40;
    localparam int W  = 3;
    localparam int S  = 3;
    localparam int BEATS = 43;

    typedef logic [127:0] v128_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [S*W-1:0]     key_i = '0, nonce_i = '0, ad_i = '0, pt_i = '0;
    logic               in_valid_i = 1'b0;
    logic               clear_i = 1'b0;
    logic               data_ack_i = 1'b0;
    logic               in_ready_o;
    logic               data_valid_o;
    logic [S*KL-1:0]    key_o;
    logic [S*NL-1:0]    nonce_o;
    logic [S*AL-1:0]    ad_o;
    logic [S*PL-1:0]    pt_o;
    logic [5:0]         beat_o;

    int n_cmp = 0;
    int n_bad = 0;

    v128_t kv, nv, av, pv;
    v128_t ks[S], ns[S], as_[S], ps[S];

    always #5 clk = ~clk;

    ascon_share_loader #(.KLEN(KL), .NLEN(NL), .ALEN(AL), .PLEN(PL), .W(W), .SHARES(S)) dut (
        .clk(clk), .rst(rst),
        .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i), .pt_i(pt_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .clear_i(clear_i),
        .key_o(key_o), .nonce_o(nonce_o), .ad_o(ad_o), .pt_o(pt_o),
        .data_valid_o(data_valid_o), .data_ack_i(data_ack_i), .beat_o(beat_o)
    );

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic v128_t rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic v128_t lenmask(input int len);
        return (v128_t'(1) << len) - v128_t'(1);
    endfunction

    // Reference: a field share is serialised as a bit stream, MSB first, W bits per beat;
    // stream positions past the field length are don't-care and get random noise.
    function automatic logic [W-1:0] lane(input v128_t v, input int len, input int b);
        logic [W-1:0] r;
        for (int j = 0; j < W; j++) begin
            int pos;
            pos = b * W + j;
            r[W-1-j] = (pos < len) ? v[len-1-pos] : 1'($urandom_range(0, 1));
        end
        return r;
    endfunction

    function automatic logic [511:0] pack(input v128_t a[S], input int len);
        logic [511:0] r;
        r = '0;
        for (int s = 0; s < S; s++) r |= 512'(a[s] & lenmask(len)) << (s * len);
        return r;
    endfunction

    task automatic set_fields(input v128_t k, input v128_t n, input v128_t a, input v128_t p);
        kv = k & lenmask(KL); nv = n & lenmask(NL); av = a & lenmask(AL); pv = p & lenmask(PL);
        ks[0] = kv; ns[0] = nv; as_[0] = av; ps[0] = pv;
        for (int s = 1; s < S; s++) begin
            ks[s]  = rand128() & lenmask(KL); ks[0]  ^= ks[s];
            ns[s]  = rand128() & lenmask(NL); ns[0]  ^= ns[s];
            as_[s] = rand128() & lenmask(AL); as_[0] ^= as_[s];
            ps[s]  = rand128() & lenmask(PL); ps[0]  ^= ps[s];
        end
    endtask

    task automatic drive_beat(input int b);
        for (int s = 0; s < S; s++) begin
            key_i[s*W +: W]   = lane(ks[s], KL, b);
            nonce_i[s*W +: W] = lane(ns[s], NL, b);
            ad_i[s*W +: W]    = lane(as_[s], AL, b);
            pt_i[s*W +: W]    = lane(ps[s], PL, b);
        end
    endtask

    task automatic drive_noise();
        key_i = (S*W)'($urandom); nonce_i = (S*W)'($urandom);
        ad_i  = (S*W)'($urandom); pt_i    = (S*W)'($urandom);
    endtask

    task automatic check_fields(input string tag);
        check({tag, "_key"},   512'(key_o),   pack(ks, KL));
        check({tag, "_nonce"}, 512'(nonce_o), pack(ns, NL));
        check({tag, "_ad"},    512'(ad_o),    pack(as_, AL));
        check({tag, "_pt"},    512'(pt_o),    pack(ps, PL));
        check({tag, "_key_xor"},   512'(key_o[0 +: KL] ^ key_o[KL +: KL] ^ key_o[2*KL +: KL]), 512'(kv));
        check({tag, "_nonce_xor"}, 512'(nonce_o[0 +: NL] ^ nonce_o[NL +: NL] ^ nonce_o[2*NL +: NL]), 512'(nv));
        check({tag, "_ad_xor"},    512'(ad_o[0 +: AL] ^ ad_o[AL +: AL] ^ ad_o[2*AL +: AL]), 512'(av));
        check({tag, "_pt_xor"},    512'(pt_o[0 +: PL] ^ pt_o[PL +: PL] ^ pt_o[2*PL +: PL]), 512'(pv));
    endtask

    // Streams beats from the negedge in LOAD until stop_at beats are accepted (bounded).
    task automatic stream(input int gap_pct, input int stop_at, output int cycles);
        int b;
        bit rdy, early, beat_bad;
        b = 0; early = 0; beat_bad = 0; cycles = 0;
        while (b < stop_at && cycles < 4000) begin
            if (beat_o !== 6'(b)) beat_bad = 1;
            if (data_valid_o !== 1'b0) early = 1;
            in_valid_i = ($urandom_range(0, 99) >= gap_pct);
            if (in_valid_i) drive_beat(b); else drive_noise();
            rdy = in_ready_o;
            @(posedge clk);
            if (in_valid_i && rdy) b++;
            @(negedge clk);
            cycles++;
        end
        in_valid_i = 1'b0;
        check("stream_beats", 512'(b), 512'(stop_at));
        check("beat_o_tracking", 512'(beat_bad), 512'(0));
        check("no_early_valid", 512'(early), 512'(0));
    endtask

    task automatic ack_after(input int delay);
        bit bad;
        bad = 0;
        repeat (delay) begin
            if (in_ready_o !== 1'b0 || data_valid_o !== 1'b1 || beat_o !== 6'(BEATS)) bad = 1;
            in_valid_i = 1'b1;
            drive_noise();
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        check("full_hold", 512'(bad), 512'(0));
        check_fields("held");
        data_ack_i = 1'b1;
        @(negedge clk);
        data_ack_i = 1'b0;
        check("ack_ready", 512'(in_ready_o), 512'(1));
        check("ack_valid", 512'(data_valid_o), 512'(0));
        check("ack_beat", 512'(beat_o), 512'(0));
`ifdef ASCON_LOADER_ZEROIZE_EN
        check("zeroize_key", 512'(key_o), 512'(0));
        check("zeroize_pt", 512'(pt_o), 512'(0));
`else
        check("retain_key", 512'(key_o), pack(ks, KL));
        check("retain_pt", 512'(pt_o), pack(ps, PL));
`endif
    endtask

    typedef struct {
        bit v; bit c; bit a;
        bit er; bit ed; int eb;
    } row_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        row_t tbl[10];
        int cyc;

        tbl[0] = '{0, 0, 0, 1, 0, 0};   // IDLE -> LOAD
        tbl[1] = '{1, 0, 0, 1, 0, 1};
        tbl[2] = '{1, 0, 0, 1, 0, 2};
        tbl[3] = '{0, 0, 0, 1, 0, 2};   // gap stalls beat_o
        tbl[4] = '{0, 0, 1, 1, 0, 2};   // ack outside FULL ignored
        tbl[5] = '{1, 1, 0, 1, 0, 0};   // clear beats a simultaneous beat
        tbl[6] = '{1, 0, 0, 1, 0, 1};
        tbl[7] = '{0, 1, 0, 1, 0, 0};
        tbl[8] = '{1, 0, 1, 1, 0, 1};
        tbl[9] = '{0, 1, 1, 1, 0, 0};

        // Reset values
        #1;
        check("rst_ready", 512'(in_ready_o), 512'(0));
        check("rst_valid", 512'(data_valid_o), 512'(0));
        check("rst_beat", 512'(beat_o), 512'(0));
        check("rst_key", 512'(key_o), 512'(0));
        check("rst_ad", 512'(ad_o), 512'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_ready", 512'(in_ready_o), 512'(0));
        @(negedge clk);

        // Control table: apply inputs at negedge, look after the following edge
        for (int i = 0; i < 10; i++) begin
            in_valid_i = tbl[i].v; clear_i = tbl[i].c; data_ack_i = tbl[i].a;
            drive_noise();
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), 512'(in_ready_o), 512'(tbl[i].er));
            check($sformatf("tbl%0d_valid", i), 512'(data_valid_o), 512'(tbl[i].ed));
            check($sformatf("tbl%0d_beat", i), 512'(beat_o), 512'(tbl[i].eb));
        end
        in_valid_i = 1'b0; clear_i = 1'b0; data_ack_i = 1'b0;

        // Load 1: reference vectors, continuous stream
        set_fields(128'h2db083053e848cefa30007336c47a5a1, 128'h3f3607dbce3503ba84f5843d623de056,
                   128'h4153434f4e, 128'h6173636f6e);
        stream(0, BEATS, cyc);
        check("load1_cycles", 512'(cyc), 512'(BEATS));
        check("load1_valid", 512'(data_valid_o), 512'(1));
        check("load1_ready", 512'(in_ready_o), 512'(0));
        check_fields("load1");
        ack_after(1);

        // Load 2: random fields, 50% gaps, late ack
        set_fields(rand128(), rand128(), rand128(), rand128());
        stream(50, BEATS, cyc);
        check_fields("load2");
        ack_after(10);

        // Abort mid-load, then full reload
        set_fields(rand128(), rand128(), rand128(), rand128());
        stream(0, 20, cyc);
        clear_i = 1'b1; in_valid_i = 1'b1; drive_noise();
        @(negedge clk);
        clear_i = 1'b0; in_valid_i = 1'b0;
        check("clear_beat", 512'(beat_o), 512'(0));
        check("clear_ready", 512'(in_ready_o), 512'(1));
        check("clear_valid", 512'(data_valid_o), 512'(0));
`ifdef ASCON_LOADER_ZEROIZE_EN
        check("clear_zero_nonce", 512'(nonce_o), 512'(0));
`endif
        set_fields(rand128(), rand128(), rand128(), rand128());
        stream(50, BEATS, cyc);
        check_fields("reload");
        ack_after(3);

        // Asynchronous reset in the middle of a load
        set_fields(rand128(), rand128(), rand128(), rand128());
        stream(0, 30, cyc);
        #2 rst = 1'b0;
        #1;
        check("arst_beat", 512'(beat_o), 512'(0));
        check("arst_ready", 512'(in_ready_o), 512'(0));
        check("arst_key", 512'(key_o), 512'(0));
        check("arst_pt", 512'(pt_o), 512'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_idle", 512'(in_ready_o), 512'(0));
        @(negedge clk);
        check("arst_load", 512'(in_ready_o), 512'(1));

        set_fields(rand128(), rand128(), rand128(), rand128());
        stream(30, BEATS, cyc);
        check_fields("final");
        ack_after(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ascon_share_loader.md
# ascon_share_loader

Parametrised serial-to-parallel input stage for the masked Ascon core. Accepts key, nonce, associated data and plaintext as W-bit-per-share lanes carrying SHARES Boolean shares per field. Assembles the full shared fields and holds them for the core behind a valid/ack handshake, with input backpressure. Generalises the fixed 1-bit, 3-share serial loading of the current core.

## Interface
- KLEN, 128, key length in bits
- NLEN, 128, nonce length in bits
- ALEN, 40, associated-data length in bits
- PLEN, 40, plaintext length in bits
- W, 1, bits per share accepted per beat (1..64)
- SHARES, 3, shares per field (1..4); share s of a lane is bits [s*W +: W]

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- key_i / nonce_i / ad_i / pt_i  in  SHARES*W  one beat of each field, MSB-first
- in_valid_i  in  1  beat present
- in_ready_o  out  1  loader accepts a beat
- clear_i  in  1  synchronous abort, discards partial load
- key_o  out  SHARES*KLEN  share s at [s*KLEN +: KLEN]; same layout for nonce_o (NLEN), ad_o (ALEN), pt_o (PLEN)
- data_valid_o  out  1  all fields complete and held
- data_ack_i  in  1  core has consumed the fields
- beat_o  out  clog2(BEATS+1)  beats accepted in current load

## Operation
- BEATS = max over fields of ceil(LEN/W); field f is active while beat_o < ceil(LEN_f/W).
- States: IDLE, LOAD, FULL. IDLE -> LOAD unconditionally one cycle after reset release.
- LOAD: in_ready_o=1. A beat is accepted on in_valid_i & in_ready_o. Each active field register, per share, shifts left by W, and the lane enters at the LSBs. Inactive fields hold.
- Final partial beat of a field (rem = LEN mod W, rem != 0): shift by rem. Take the most-significant rem bits of each share's lane, [s*W+W-1 : s*W+W-rem].
- The BEATS-th accepted beat moves LOAD -> FULL.
- FULL: in_ready_o=0, data_valid_o=1, outputs stable. data_ack_i -> LOAD with beat_o=0. Field registers are retained unless zeroized (see Configuration).
- data_ack_i outside FULL is ignored.
- clear_i: from any state -> LOAD, beat_o=0, data_valid_o=0. Fields are retained unless zeroized. clear_i wins over a simultaneous beat or ack.
- Shares are stored unmodified; no recombination of shares anywhere in the block.

## Timing
- Reset values: state IDLE, in_ready_o=0, data_valid_o=0, beat_o=0, all field outputs 0.
- in_ready_o and data_valid_o are decoded from registered state only; there is no combinational path from any input.
- With in_valid_i held high: data_valid_o rises on the edge after the BEATS-th beat, i.e. BEATS+1 cycles after entering LOAD.
- Acknowledge: data_ack_i sampled high in FULL -> in_ready_o=1 on the next cycle. Minimum load-to-load period is BEATS+1 cycles.
- Gaps in in_valid_i stall beat_o with no data change.
- Reset asserted mid-load returns to reset values immediately, asynchronously.

## Configuration
- ASCON_LOADER_ZEROIZE_EN defined: on data_ack_i in FULL, or on clear_i, all field registers are cleared to 0 on the same edge that leaves FULL or aborts. Required for masked builds so stale shares do not persist.
- Not defined: field registers keep their last value until overwritten by shifting. Behaviour is otherwise identical.

## Test plan
- Default params, share0 = data, shares 1,2 = $random. Key 0x2db083053e848cefa30007336c47a5a1, nonce 0x3f3607dbce3503ba84f5843d623de056, AD 0x4153434f4e, PT 0x6173636f6e, streamed for 128 beats -> data_valid_o on cycle 129. XOR of the three shares equals each vector. ad_o/pt_o stop shifting after beat 40.
- W=8, same vectors -> 16 beats. Exact share values match a software model.
- W=3 (non-divisible) -> 43 beats. Key last beat uses lane bits [2:1] per share, AD last beat (beat 14) uses bit [2]. Reconstructed fields match.
- Random in_valid_i gaps (50%) plus data_ack_i delayed 10 cycles -> same fields. in_ready_o=0 throughout FULL; a second load starts the cycle after ack.
- clear_i at beat 60, then full reload -> correct fields, beat_o restarts at 0. rst pulsed at beat 30 -> all outputs 0, IDLE, then LOAD.
- Zeroize: with ASCON_LOADER_ZEROIZE_EN, key_o..pt_o read 0 the cycle after ack. Without it, the previous values remain.
